// File: rtl/lenet_layer_seq.sv
// Layer sequencer for the LeNet accelerator: runs conv_1, pool_1, conv_2, pool_2 and fc in
// order. Each layer gets a reset pulse, then a steady enable, then a gap before the next.
module lenet_layer_seq #(
   parameter int NUM_LAYERS = 5,
   parameter int CLR_CYCLES = 2,
   parameter int GAP_CYCLES = 4,
   parameter int TIMEOUT    = 2**20-1,
   parameter int IDX_W      = 3
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic                  abort,
   input  logic [NUM_LAYERS-1:0] layer_finish,
   output logic [NUM_LAYERS-1:0] layer_en,
   output logic [NUM_LAYERS-1:0] layer_rst,
   output logic [IDX_W-1:0]      mac_sel,
   output logic                  fm_bank_sel,
   output logic [IDX_W-1:0]      cur_layer,
   output logic                  busy,
   output logic                  done,
   output logic                  err
);

   localparam int TC_W = $clog2(TIMEOUT + 1);
   localparam int PH_W = $clog2(CLR_CYCLES + GAP_CYCLES + 1);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_CLR  = 3'd1,
      S_RUN  = 3'd2,
      S_GAP  = 3'd3,
      S_FIN  = 3'd4,
      S_ERR  = 3'd5,
      S_ABRT = 3'd6
   } state_t;

   state_t                  state_r, state_s;
   logic [IDX_W-1:0]        k_r, k_s;
   logic                    bank_r, bank_s;
   logic [PH_W-1:0]         ph_r, ph_s;
   logic [TC_W-1:0]         tc_r, tc_s;
   logic [NUM_LAYERS-1:0]   en_s, lrst_s;
   logic                    done_s, busy_s, err_s;
   logic [NUM_LAYERS-1:0]   onehot_s;

   assign mac_sel     = k_r;
   assign cur_layer   = k_r;
   assign fm_bank_sel = bank_r;

   // Next-state, layer index, bank and phase/timeout counters
   always_comb begin
      state_s = state_r;
      k_s     = k_r;
      bank_s  = bank_r;
      ph_s    = ph_r;
      tc_s    = tc_r;
      case (state_r)
         S_IDLE: begin
            if (start && !abort) begin
               state_s = S_CLR;
               k_s     = {IDX_W{1'b0}};
               bank_s  = 1'b0;
               ph_s    = {PH_W{1'b0}};
               tc_s    = {TC_W{1'b0}};
            end else begin
               state_s = S_IDLE;
            end
         end
         S_CLR: begin
            if (abort) begin
               state_s = S_ABRT;
               ph_s    = {PH_W{1'b0}};
            end else if (ph_r == PH_W'(CLR_CYCLES - 1)) begin
               state_s = S_RUN;
               ph_s    = {PH_W{1'b0}};
            end else begin
               ph_s = ph_r + PH_W'(1);
            end
         end
         S_RUN: begin
            // only the running layer's finish bit matters; stale bits of others are ignored
            if (abort) begin
               state_s = S_ABRT;
               ph_s    = {PH_W{1'b0}};
            end else if (layer_finish[k_r]) begin
               state_s = (k_r == IDX_W'(NUM_LAYERS - 1)) ? S_FIN : S_GAP;
               ph_s    = {PH_W{1'b0}};
            end else if (tc_r == TC_W'(TIMEOUT - 1)) begin
               state_s = S_ERR;
            end else begin
               tc_s = tc_r + TC_W'(1);
            end
         end
         S_GAP: begin
            if (abort) begin
               state_s = S_ABRT;
               ph_s    = {PH_W{1'b0}};
            end else if (ph_r == PH_W'(GAP_CYCLES - 1)) begin
               state_s = S_CLR;
               k_s     = k_r + IDX_W'(1);
               bank_s  = ~bank_r;
               ph_s    = {PH_W{1'b0}};
               tc_s    = {TC_W{1'b0}};
            end else begin
               ph_s = ph_r + PH_W'(1);
            end
         end
         S_FIN: begin
            if (abort) begin
               state_s = S_ABRT;
               ph_s    = {PH_W{1'b0}};
            end else begin
               state_s = S_IDLE;
            end
         end
         S_ERR: begin
            if (abort) begin
               state_s = S_IDLE;
            end else if (start) begin
               state_s = S_CLR;
               k_s     = {IDX_W{1'b0}};
               bank_s  = 1'b0;
               ph_s    = {PH_W{1'b0}};
               tc_s    = {TC_W{1'b0}};
            end else begin
               state_s = S_ERR;
            end
         end
         S_ABRT: begin
            if (ph_r == PH_W'(CLR_CYCLES - 1)) begin
               state_s = S_IDLE;
               ph_s    = {PH_W{1'b0}};
            end else begin
               ph_s = ph_r + PH_W'(1);
            end
         end
         default: begin
            state_s = S_IDLE;
         end
      endcase
   end

   // Output values decoded from the state being entered, so they line up with it once registered
   always_comb begin
      onehot_s = {{(NUM_LAYERS-1){1'b0}}, 1'b1} << k_s;
      en_s     = {NUM_LAYERS{1'b0}};
      lrst_s   = {NUM_LAYERS{1'b0}};
      done_s   = 1'b0;
      err_s    = 1'b0;
      busy_s   = (state_s != S_IDLE) && (state_s != S_ERR);
      case (state_s)
         S_CLR:   lrst_s = onehot_s;
         S_RUN:   en_s   = onehot_s;
         S_ABRT:  lrst_s = {NUM_LAYERS{1'b1}};
         S_FIN:   done_s = 1'b1;
         S_ERR:   err_s  = 1'b1;
         default: en_s   = {NUM_LAYERS{1'b0}};
      endcase
   end

   // State, counters and registered outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r   <= S_IDLE;
         k_r       <= {IDX_W{1'b0}};
         bank_r    <= 1'b0;
         ph_r      <= {PH_W{1'b0}};
         tc_r      <= {TC_W{1'b0}};
         layer_en  <= {NUM_LAYERS{1'b0}};
         layer_rst <= {NUM_LAYERS{1'b0}};
         busy      <= 1'b0;
         done      <= 1'b0;
         err       <= 1'b0;
      end else begin
         state_r   <= state_s;
         k_r       <= k_s;
         bank_r    <= bank_s;
         ph_r      <= ph_s;
         tc_r      <= tc_s;
         layer_en  <= en_s;
         layer_rst <= lrst_s;
         busy      <= busy_s;
         done      <= done_s;
         err       <= err_s;
      end
   end

endmodule
